// File: rtl/sumador_pkg.sv
// Shared definitions for the sumador accumulator slice: op encoding and default width.
package sumador_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

endpackage

// File: rtl/sumador_core.sv
// Combinational arithmetic for sumador_acc: add/sub/accumulate with carry,
// signed overflow detection and optional signed saturation.
module sumador_core
  import sumador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SAT   = 0
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  op_e              op_s;
  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] y_s;
  logic             cin_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] raw_s;
  logic             ovf_s;

  assign op_s = op_e'(op);

  // Operand routing: SUB adds the inverted b plus one, ACC adds a to acc.
  always_comb begin
    x_s   = a;
    y_s   = b;
    cin_s = 1'b0;
    case (op_s)
      OP_ADD: begin
        x_s = a;
        y_s = b;
      end
      OP_SUB: begin
        x_s   = a;
        y_s   = ~b;
        cin_s = 1'b1;
      end
      OP_ACC: begin
        x_s = acc;
        y_s = a;
      end
      OP_CLR: begin
        x_s = {WIDTH{1'b0}};
        y_s = {WIDTH{1'b0}};
      end
      default: begin
        x_s = a;
        y_s = b;
      end
    endcase
  end

  assign sum_s = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, cin_s};
  assign raw_s = sum_s[WIDTH-1:0];
  // With y = ~b for SUB, "equal operand signs" covers both the add and sub overflow rule.
  assign ovf_s = (x_s[WIDTH-1] == y_s[WIDTH-1]) && (raw_s[WIDTH-1] != x_s[WIDTH-1]);

  // Flag selection and saturation; a clean sum carry-out means no borrow on SUB.
  always_comb begin
    res      = raw_s;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op_s)
      OP_ADD, OP_ACC: begin
        carry    = sum_s[WIDTH];
        overflow = ovf_s;
      end
      OP_SUB: begin
        carry    = ~sum_s[WIDTH];
        overflow = ovf_s;
      end
      OP_CLR: begin
        carry    = 1'b0;
        overflow = 1'b0;
      end
      default: begin
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
    if (op_s == OP_CLR) begin
      res = {WIDTH{1'b0}};
    end else if ((SAT != 0) && overflow) begin
      res = x_s[WIDTH-1] ? SMIN : SMAX;
    end else begin
      res = raw_s;
    end
  end

endmodule

// File: rtl/sumador_acc.sv
// Adder/accumulator with valid/ready handshake on both sides; results and
// flags are registered with one cycle of latency.
module sumador_acc
  import sumador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  logic             accept_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic             overflow_r;
  logic             zero_r;
  logic [WIDTH-1:0] acc_r;

  sumador_core #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_core (
    .op       (op),
    .a        (a),
    .b        (b),
    .acc      (acc_r),
    .res      (res_s),
    .carry    (carry_s),
    .overflow (ovf_s)
  );

  // The output stage frees up in the same cycle the consumer takes it.
  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  // Output registers, handshake state and the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      acc_r       <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      result_r    <= res_s;
      carry_r     <= carry_s;
      overflow_r  <= ovf_s;
      zero_r      <= (res_s == {WIDTH{1'b0}});
      if (op == OP_ACC) begin
        acc_r <= res_s;
      end else if (op == OP_CLR) begin
        acc_r <= {WIDTH{1'b0}};
      end else begin
        acc_r <= acc_r;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign carry     = carry_r;
  assign overflow  = overflow_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_sumador_acc.sv
// Bench for sumador_acc: wrap (SAT=0) and saturating (SAT=1) instances share
// stimulus and are compared against an integer-arithmetic reference model.
module tb_sumador_acc;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       out_ready;

  logic       in_ready0, out_valid0, carry0, overflow0, zero0;
  logic [7:0] result0;
  logic       in_ready1, out_valid1, carry1, overflow1, zero1;
  logic [7:0] result1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       o;
    logic       z;
  } exp_t;

  exp_t e0, e1;
  bit   ev;
  int   acc0, acc1;

  sumador_acc #(.WIDTH(8), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .carry(carry0), .overflow(overflow0), .zero(zero0)
  );

  sumador_acc #(.WIDTH(8), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .carry(carry1), .overflow(overflow1), .zero(zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sx(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model_op(input bit sat, input logic [1:0] o,
                                    input int ua, input int ub, input int uacc);
    exp_t e;
    int us, ss;
    us = 0; ss = 0;
    e = '0;
    case (o)
      2'd0: begin us = ua + ub;   ss = sx(ua) + sx(ub);   e.c = (us > 255); end
      2'd1: begin us = ua - ub;   ss = sx(ua) - sx(ub);   e.c = (ua < ub);  end
      2'd2: begin us = uacc + ua; ss = sx(uacc) + sx(ua); e.c = (us > 255); end
      default: begin us = 0; ss = 0; e.c = 1'b0; end
    endcase
    e.o = (ss > 127) || (ss < -128);
    e.r = us[7:0];
    if (sat && e.o) e.r = (ss > 127) ? 8'h7F : 8'h80;
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".wrap.valid"}, {31'd0, out_valid0}, {31'd0, ev});
    chk({tag, ".sat.valid"},  {31'd0, out_valid1}, {31'd0, ev});
    chk({tag, ".wrap.out"}, {20'd0, result0, carry0, overflow0, zero0}, {20'd0, e0});
    chk({tag, ".sat.out"},  {20'd0, result1, carry1, overflow1, zero1}, {20'd0, e1});
  endtask

  // One clock of stimulus: drive on negedge, check ready, update model on posedge.
  task automatic step(input string tag, input bit iv, input logic [1:0] o,
                      input logic [7:0] va, input logic [7:0] vb, input bit ordy);
    bit rdy;
    @(negedge clk);
    in_valid = iv; op = o; a = va; b = vb; out_ready = ordy;
    #1;
    rdy = !ev || ordy;
    chk({tag, ".wrap.in_ready"}, {31'd0, in_ready0}, {31'd0, rdy});
    chk({tag, ".sat.in_ready"},  {31'd0, in_ready1}, {31'd0, rdy});
    @(posedge clk);
    if (iv && rdy) begin
      e0 = model_op(1'b0, o, int'(va), int'(vb), acc0);
      e1 = model_op(1'b1, o, int'(va), int'(vb), acc1);
      if (o == 2'd2) begin acc0 = int'(e0.r); acc1 = int'(e1.r); end
      if (o == 2'd3) begin acc0 = 0; acc1 = 0; end
      ev = 1'b1;
    end else if (ordy) begin
      ev = 1'b0;
    end
    #1;
    chk_outputs(tag);
  endtask

  task automatic model_reset();
    ev = 1'b0; e0 = '0; e1 = '0; acc0 = 0; acc1 = 0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 2'd0; out_ready = 1'b1;
    model_reset();
    #3;
    chk_outputs("reset");
    chk("reset.in_ready", {31'd0, in_ready0}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    step("add_ff_01", 1'b1, 2'd0, 8'hFF, 8'h01, 1'b1);
    chk("add_ff_01.lit", {20'd0, result0, carry0, overflow0, zero0}, {20'd0, 8'h00, 1'b1, 1'b0, 1'b1});
    step("add_7f_01", 1'b1, 2'd0, 8'h7F, 8'h01, 1'b1);
    chk("add_7f_01.wrap.lit", {23'd0, result0, overflow0}, {23'd0, 8'h80, 1'b1});
    chk("add_7f_01.sat.lit",  {23'd0, result1, overflow1}, {23'd0, 8'h7F, 1'b1});
    step("sub_03_05", 1'b1, 2'd1, 8'h03, 8'h05, 1'b1);
    chk("sub_03_05.lit", {22'd0, result0, carry0, overflow0}, {22'd0, 8'hFE, 1'b1, 1'b0});
    step("sub_80_01", 1'b1, 2'd1, 8'h80, 8'h01, 1'b1);
    chk("sub_80_01.sat.lit", {23'd0, result1, overflow1}, {23'd0, 8'h80, 1'b1});
    step("add_81_81", 1'b1, 2'd0, 8'h81, 8'h81, 1'b1);
    step("idle", 1'b0, 2'd0, 8'h00, 8'h00, 1'b1);

    step("clr", 1'b1, 2'd3, 8'h55, 8'hAA, 1'b1);
    chk("clr.lit", {24'd0, result0}, 32'h00);
    step("acc_0a", 1'b1, 2'd2, 8'h0A, 8'h77, 1'b1);
    chk("acc_0a.lit", {24'd0, result0}, 32'h0A);
    step("acc_14", 1'b1, 2'd2, 8'h14, 8'h00, 1'b1);
    chk("acc_14.lit", {24'd0, result0}, 32'h1E);
    step("acc_1e", 1'b1, 2'd2, 8'h1E, 8'h00, 1'b1);
    chk("acc_1e.lit", {24'd0, result0}, 32'h3C);

    for (int i = 0; i < 5; i++) begin
      step("stall", 1'b1, 2'd0, 8'h11, 8'h22, 1'b0);
      chk("stall.held", {24'd0, result0}, 32'h3C);
    end
    step("release", 1'b1, 2'd0, 8'h11, 8'h22, 1'b1);
    chk("release.lit", {24'd0, result0}, 32'h33);

    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset.in_ready", {30'd0, in_ready0, in_ready1}, 32'd3);
    step("acc_after_reset", 1'b1, 2'd2, 8'h01, 8'h00, 1'b1);
    chk("acc_after_reset.lit", {24'd0, result0}, 32'h01);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sumador_acc.md
SUMADOR_ACC -- requirements
Module: sumador_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter SAT, default 0, where 1 enables signed saturation of ADD/SUB/ACC results.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, with asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1, which indicates that a, b and op are valid.
REQ-006 SHALL have port in_ready, output, 1, which indicates that the block accepts the request this cycle.
REQ-007 SHALL have port a, input, WIDTH, operand A.
REQ-008 SHALL have port b, input, WIDTH, operand B (ignored for ACC/CLR).
REQ-009 SHALL have port op, input, 2, with encoding 00 ADD, 01 SUB, 10 ACC, 11 CLR.
REQ-010 SHALL have port out_valid, output, 1, which indicates that result and the flags are valid.
REQ-011 SHALL have port out_ready, input, 1, which indicates that the consumer takes the result this cycle.
REQ-012 SHALL have port result, output, WIDTH, the registered result.
REQ-013 SHALL have ports carry, overflow and zero, each an output of width 1, as registered flags.

Function
REQ-014 SHALL define accept as in_valid && in_ready; in_ready SHALL be the combinational value !out_valid || out_ready.
REQ-015 SHALL register result and flags, and set out_valid=1, on the clock edge of an accept (latency 1 cycle).
REQ-016 SHALL clear out_valid on an edge with out_valid && out_ready and no accept; when acceptance and consumption occur together, out_valid SHALL stay 1 with the new data.
REQ-017 SHALL hold result and flags stable while out_valid && !out_ready.
REQ-018 SHALL compute the operations as follows: ADD is a+b; SUB is a-b (two's complement, a + ~b + 1); ACC is acc+a, with acc <= that result; CLR gives acc <= 0 and result 0.
REQ-019 SHALL change the internal WIDTH-bit register acc only on an accepted ACC or CLR.
REQ-020 SHALL set carry as follows: for ADD/ACC, the unsigned carry-out of bit WIDTH-1; for SUB, the borrow (1 when a < b, unsigned); for CLR, 0.
REQ-021 SHALL set overflow as follows: for ADD/ACC, 1 when the operands have equal sign and the raw result's sign differs; for SUB, 1 when the operands have different signs and the raw result's sign differs from a; for CLR, 0.
REQ-022 SHALL, when SAT=1 and overflow=1, replace the result with the signed max (0111..1) on positive overflow or the signed min (1000..0) on negative overflow; acc SHALL store the saturated value and the overflow flag SHALL remain 1.
REQ-023 SHALL keep the unsaturated result when SAT=0 (wrap-around).
REQ-024 SHALL set zero=1 exactly when the registered result (post-saturation) is 0.
REQ-025 SHALL leave the result width at WIDTH bits, with no sign or width extension on the outputs.

Reset
REQ-026 SHALL, while rst_n=0, force out_valid=0, result=0, carry=0, overflow=0, zero=0 and acc=0 immediately, independent of clk.
REQ-027 SHALL drop any result in flight when reset is asserted mid-transaction; after release, in_ready SHALL be 1 in the first cycle.

Structure
REQ-028 SHALL take the op encoding constants (OP_ADD, OP_SUB, OP_ACC, OP_CLR) and the default WIDTH from the shared package sumador_pkg.
REQ-029 SHALL place the arithmetic (add/sub, carry, overflow, saturation) in the combinational sub-module sumador_core, parametrised by WIDTH and SAT; sumador_acc SHALL contain the handshake, acc and output registers.

Verification (WIDTH=8)
REQ-030 SHALL cover this scenario: ADD a=0xFF b=0x01 accepted -> next cycle out_valid=1, result=0x00, carry=1, overflow=0, zero=1.
REQ-031 SHALL cover this scenario: ADD a=0x7F b=0x01 -> with SAT=0, result=0x80 and overflow=1; with SAT=1, result=0x7F and overflow=1.
REQ-032 SHALL cover this scenario: SUB a=0x03 b=0x05 -> result=0xFE, carry=1, overflow=0; SUB a=0x80 b=0x01 with SAT=1 -> result=0x80, overflow=1.
REQ-033 SHALL cover this scenario: CLR, then ACC a=0x0A, 0x14, 0x1E back-to-back with out_ready=1 -> results 0x00, 0x0A, 0x1E, 0x3C on consecutive cycles.
REQ-034 SHALL cover this scenario: out_valid=1 with out_ready=0 and in_valid held -> in_ready=0 and result unchanged for 5 cycles; raising out_ready -> the held request is accepted in the same cycle and its result appears on the next cycle.
REQ-035 SHALL cover this scenario: rst_n pulled low mid-cycle while out_valid=1 and acc=0x3C -> out_valid=0 without a clock edge; after release, ACC a=0x01 -> result=0x01.
